// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the FSM state encoding, opcode and funct field values, the ALU
// operation codes driven on alucontrol, and the internal aluop codes that
// pass from the main FSM to the ALU decoder.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle.
// Inputs to the controller: op, funct (straight from the IR), zero (ALU flag).
// Outputs: enables/strobes (pcen, memwrite, irwrite, regwrite), mux selects
// (alusrca, alusrcb, iord, memtoreg, regdst, pcsrc), alucontrol, and the
// debug state number.
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
           memtoreg, regdst, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
           memtoreg, regdst, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop plus the R-type funct field onto the
// 3-bit ALU operation code.
// Ports: aluop (in, 2), funct (in, 6), alucontrol (out, 3).
module mc_aludec
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FN: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: 12-state FSM sequencing LW, SW, R-type,
// BEQ, ADDI and J through fetch/decode/execute/memory/writeback.
// Ports: clk, reset (synchronous, active-high, forces FETCH), bus
// (mc_controller_if.master: op/funct/zero in, datapath controls out).
// All controls are decoded from the current state only, except pcen (mixes in
// zero) and alucontrol (mixes in funct). op/funct are never stored: the IR
// holds the instruction stable while it executes.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Anything that is not LW here must be SW, since only those reach MEMADR.
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    pcsrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FN;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller. A driver issues instructions (directed, then
// random) and pushes the per-cycle expected state and controls into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  typedef int seq_t[$];

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] valid_ops[6]   = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] known_fns[5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] known_alu[5]   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  // ALU operation an R-type instruction asks for.
  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    for (int k = 0; k < 5; k++)
      if (known_fns[k] == fn) return known_alu[k];
    return 3'b010;
  endfunction

  // Sequence of states an instruction visits, starting at FETCH.
  function automatic seq_t path(input logic [5:0] op);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b000100: return '{0, 1, 8};
      6'b001000: return '{0, 1, 9, 10};
      6'b000010: return '{0, 1, 11};
      default:   return '{0, 1};
    endcase
  endfunction

  // Controls required in a given state.
  function automatic outs_t model_outs(input int s, input logic [5:0] fn, input logic z);
    outs_t o;
    o = '0;
    o.aluc = 3'b010;
    case (s)
      0:  begin o.irwrite = 1; o.pcen = 1; o.alusrcb = 2'b01; end
      1:  o.alusrcb = 2'b11;
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.memtoreg = 1; o.regwrite = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; end
      6:  begin o.alusrca = 1; o.aluc = rtype_alu(fn); end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.alusrca = 1; o.pcsrc = 2'b01; o.aluc = 3'b110; o.pcen = z; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1;
      11: begin o.pcsrc = 2'b10; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic exp_t mk(input int s, input logic [5:0] fn, input logic z);
    exp_t e;
    e.st = 4'(s);
    e.o  = model_outs(s, fn, z);
    return e;
  endfunction

  // Called just after a rising edge with the DUT in FETCH. cut < 0 runs the
  // whole instruction; otherwise reset is raised during state number cut-1
  // of the path and held for hold edges.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int cut, input int hold);
    seq_t p;
    int   n;
    p = path(op);
    n = (cut < 0) ? p.size() : cut;
    bus.op    = op;
    bus.funct = fn;
    bus.zero  = z;
    for (int i = 0; i < n; i++) begin
      sb.push_back(mk(p[i], fn, z));
      if (i < n - 1 || cut < 0) begin
        @(posedge clk); #1;
      end
    end
    if (cut >= 0) begin
      reset  = 1'b1;
      bus.op = 6'b100011;
      for (int j = 0; j < hold; j++) begin
        @(posedge clk); #1;
        if (j < hold - 1) sb.push_back(mk(0, fn, z));
        else              reset = 1'b0;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t  e;
    outs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.pcen = bus.pcen; a.memwrite = bus.memwrite; a.irwrite = bus.irwrite;
      a.regwrite = bus.regwrite; a.alusrca = bus.alusrca; a.alusrcb = bus.alusrcb;
      a.iord = bus.iord; a.memtoreg = bus.memtoreg; a.regdst = bus.regdst;
      a.pcsrc = bus.pcsrc; a.aluc = bus.alucontrol;
      total++;
      if (bus.state !== e.st) begin
        bad++;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc, bus.state, e.st);
      end
      total++;
      if (a !== e.o) begin
        bad++;
        $display("FAIL outputs cyc=%0d state=%0d actual=%h required=%h", cyc, e.st, a, e.o);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    logic       z;
    int         r, cut, hold;
    seq_t       p;
    reset = 1'b1;
    bus.op = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    @(posedge clk); #1;
    sb.push_back(mk(0, bus.funct, bus.zero));
    @(posedge clk); #1;
    sb.push_back(mk(0, bus.funct, bus.zero));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed instructions
    run_instr(6'b100011, 6'b000000, 1'b0, -1, 0);
    run_instr(6'b101011, 6'b000000, 1'b1, -1, 0);
    run_instr(6'b000100, 6'b000000, 1'b1, -1, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, -1, 0);
    run_instr(6'b000000, 6'b100000, 1'b0, -1, 0);
    run_instr(6'b000000, 6'b100010, 1'b1, -1, 0);
    run_instr(6'b000000, 6'b100100, 1'b0, -1, 0);
    run_instr(6'b000000, 6'b100101, 1'b0, -1, 0);
    run_instr(6'b000000, 6'b101010, 1'b0, -1, 0);
    run_instr(6'b000000, 6'b111111, 1'b0, -1, 0);
    run_instr(6'b001000, 6'b000000, 1'b0, -1, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, -1, 0);
    run_instr(6'b000010, 6'b000000, 1'b1, -1, 0);
    // Reset while in MEMRD, held one edge, then held three edges.
    run_instr(6'b100011, 6'b000000, 1'b0, 4, 1);
    run_instr(6'b100011, 6'b000000, 1'b0, 4, 3);
    run_instr(6'b000000, 6'b100000, 1'b0, -1, 0);

    // Random instructions
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 7);
      op = (r < 6) ? valid_ops[r] : 6'($urandom);
      r  = $urandom_range(0, 9);
      fn = (r < 5) ? known_fns[r] : 6'($urandom);
      z  = 1'($urandom);
      p  = path(op);
      if ($urandom_range(0, 19) == 0) begin
        cut  = $urandom_range(1, p.size());
        hold = $urandom_range(1, 3);
        run_instr(op, fn, z, cut, hold);
      end else begin
        run_instr(op, fn, z, -1, 0);
      end
    end

    @(negedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have the following ports, one clock domain, all outputs Moore (state-decoded) except pcen and alucontrol:
- clk  in  1  sole clock; all state updates occur on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- op  in  6  instruction opcode, IR[31:26].
- funct  in  6  R-type function field, IR[5:0].
- zero  in  1  ALU zero flag.
- pcen  out  1  PC register enable.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  register write-data select: 1 = Data, 0 = ALUOut.
- regdst  out  1  destination select: 1 = rd, 0 = rt.
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation code.
- state  out  4  current FSM state, for debug only.

Function
REQ-002 The FSM SHALL have 12 states with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-003 The opcodes SHALL be LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-004 The FSM SHALL make these transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR for LW/SW, EXECUTE for RTYPE, BRANCH for BEQ, ADDIEX for ADDI, JUMP for J.
- DECODE -> FETCH for any other opcode (treated as a NOP).
REQ-005 The FSM SHALL continue as follows:
- MEMADR -> MEMRD for LW, MEMWR for SW.
- MEMRD -> MEMWB.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
- Unused encodings 12-15 -> FETCH.
REQ-006 Each state SHALL assert only the signals listed below; every unlisted output SHALL be 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-007 pcen SHALL equal pcwrite OR (branch AND zero), combinationally, in the same cycle.
REQ-008 alucontrol SHALL be decoded as follows:
- aluop 00 -> 010 (add).
- aluop 01 -> 110 (sub).
- aluop 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
- aluop 11 -> 010.
REQ-009 Instruction latencies, FETCH to FETCH inclusive, SHALL be: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, undefined opcode 2.
REQ-010 op and funct SHALL be sampled combinationally from the IR every cycle; the FSM SHALL NOT store a copy of them.

Reset
REQ-011 When reset=1 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-012 After reset, outputs SHALL take the FETCH values: irwrite=1, pcwrite=1, pcen=1, all write strobes other than irwrite 0. The datapath PC reset has priority over pcen.
REQ-013 While reset is held, the FSM SHALL remain in FETCH, and memwrite and regwrite SHALL stay 0.

Structure
REQ-014 A shared package SHALL hold the state enum, the opcode constants, the funct constants and the alucontrol constants.
REQ-015 The ALU decoder SHALL be a separate sub-module named mc_aludec, with inputs aluop and funct and output alucontrol.
REQ-016 The state register SHALL be a single always_ff block, and next-state and output decode SHALL be in always_comb blocks.

Verification
REQ-017 Reset then op=100011: the bench SHALL observe states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-018 op=101011: the bench SHALL observe states 0,1,2,5,0; memwrite=1 and iord=1 for exactly one cycle.
REQ-019 op=000100 with zero=1: pcen=1 in BRANCH; with zero=0: pcen=0 in BRANCH; the next state SHALL be FETCH in both cases.
REQ-020 op=000000 with funct 100000/100010/100100/100101/101010/111111: alucontrol in EXECUTE SHALL be 010/110/000/001/111/010 respectively; ALUWB SHALL assert regdst=1.
REQ-021 op=111111: the bench SHALL observe states 0,1,0 with no memwrite or regwrite pulse; op=000010: states 0,1,11,0 with pcsrc=10 and pcen=1 in JUMP.
REQ-022 Reset asserted in MEMRD: the state SHALL be FETCH on the next edge, and MEMWB SHALL never be entered, so no regwrite pulse occurs.
